// File: rtl/ppu_vbuf_page_sched.sv
// Double-buffer page scheduler for the 2-page video buffer.
// Chooses the scanout page and the render page. Pages swap only on the
// LCD frame boundary. The PPU frame-done toggle is synchronized into the
// LCD domain. The block keeps drop, repeat and stall statistics.
module ppu_vbuf_page_sched #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_FRAMES = 8,
  parameter int CNT_W          = 16
) (
  input  logic             i_lcd_clk,
  input  logic             i_lcd_rstn,
  input  logic             i_sync_en,
  input  logic             i_frame_end,
  input  logic             i_ppu_done_tgl,
  input  logic             i_cnt_clr,
  output logic             o_rd_page,
  output logic             o_wr_page,
  output logic             o_swap,
  output logic             o_pending,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic [CNT_W-1:0] o_repeat_cnt,
  output logic             o_ppu_stall
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   edge_prev_r;
  logic                   done_s;
  state_e                 state_r, state_nxt_s;
  logic                   sync_swap_s;
  logic                   free_swap_s;
  logic                   drop_inc_s;
  logic                   repeat_inc_s;
  logic [7:0]             timer_r, timer_nxt_s;

  // Synchronizer chain and edge-detect flop for the asynchronous done toggle.
  always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
    if (!i_lcd_rstn) begin
      sync_r      <= '0;
      edge_prev_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[SYNC_STAGES-2:0], i_ppu_done_tgl};
      edge_prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Each completed PPU frame is seen as one edge of the synchronized level.
  assign done_s = sync_r[SYNC_STAGES-1] ^ edge_prev_r;

  // Next state, swap requests and statistics increments.
  always_comb begin
    state_nxt_s  = state_r;
    sync_swap_s  = 1'b0;
    free_swap_s  = 1'b0;
    drop_inc_s   = 1'b0;
    repeat_inc_s = 1'b0;
    if (i_sync_en) begin
      case (state_r)
        ST_IDLE: begin
          if (done_s && i_frame_end) begin
            sync_swap_s = 1'b1;
          end else if (done_s) begin
            state_nxt_s = ST_PENDING;
          end else if (i_frame_end) begin
            repeat_inc_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PENDING: begin
          // A newer frame overwrote the waiting one; the newer one is shown.
          drop_inc_s = done_s;
          if (i_frame_end) begin
            sync_swap_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_PENDING;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      // Free-run mode: any waiting frame is discarded.
      state_nxt_s = ST_IDLE;
      free_swap_s = i_frame_end;
    end
  end

  // Stall timer next value: counts frames without a done, frozen in free-run.
  always_comb begin
    timer_nxt_s = timer_r;
    if (i_cnt_clr) begin
      timer_nxt_s = 8'd0;
    end else if (!i_sync_en) begin
      timer_nxt_s = timer_r;
    end else if (done_s) begin
      timer_nxt_s = 8'd0;
    end else if (i_frame_end && (timer_r < TIMEOUT_C)) begin
      timer_nxt_s = timer_r + 8'd1;
    end else begin
      timer_nxt_s = timer_r;
    end
  end

  // State, page bits, swap pulse and pending flag.
  always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
    if (!i_lcd_rstn) begin
      state_r   <= ST_IDLE;
      o_rd_page <= 1'b1;
      o_wr_page <= 1'b0;
      o_swap    <= 1'b0;
      o_pending <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      o_swap    <= sync_swap_s | free_swap_s;
      o_pending <= (state_nxt_s == ST_PENDING);
      if (sync_swap_s) begin
        o_rd_page <= o_wr_page;
        o_wr_page <= ~o_wr_page;
      end else if (free_swap_s) begin
        o_rd_page <= ~o_rd_page;
        o_wr_page <= ~o_wr_page;
      end
    end
  end

  // Saturating statistics counters; clear wins over increment.
  always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
    if (!i_lcd_rstn) begin
      o_drop_cnt   <= '0;
      o_repeat_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_drop_cnt   <= '0;
      o_repeat_cnt <= '0;
    end else begin
      if (drop_inc_s && (o_drop_cnt != CNT_MAX_C)) begin
        o_drop_cnt <= o_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (repeat_inc_s && (o_repeat_cnt != CNT_MAX_C)) begin
        o_repeat_cnt <= o_repeat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stall timer and its registered timeout flag.
  always_ff @(posedge i_lcd_clk or negedge i_lcd_rstn) begin
    if (!i_lcd_rstn) begin
      timer_r     <= 8'd0;
      o_ppu_stall <= 1'b0;
    end else begin
      timer_r     <= timer_nxt_s;
      o_ppu_stall <= (timer_nxt_s == TIMEOUT_C);
    end
  end

endmodule

// File: tb/tb_ppu_vbuf_page_sched.sv
// Directed testbench for ppu_vbuf_page_sched with hand-computed expectations.
module tb_ppu_vbuf_page_sched;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rstn;
  logic             sync_en;
  logic             frame_end;
  logic             done_tgl;
  logic             cnt_clr;
  logic             rd_page;
  logic             wr_page;
  logic             swap;
  logic             pending;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] repeat_cnt;
  logic             ppu_stall;

  int errors = 0;
  int checks = 0;

  ppu_vbuf_page_sched #(
    .SYNC_STAGES(2),
    .TIMEOUT_FRAMES(8),
    .CNT_W(CNT_W)
  ) dut (
    .i_lcd_clk(clk),
    .i_lcd_rstn(rstn),
    .i_sync_en(sync_en),
    .i_frame_end(frame_end),
    .i_ppu_done_tgl(done_tgl),
    .i_cnt_clr(cnt_clr),
    .o_rd_page(rd_page),
    .o_wr_page(wr_page),
    .o_swap(swap),
    .o_pending(pending),
    .o_drop_cnt(drop_cnt),
    .o_repeat_cnt(repeat_cnt),
    .o_ppu_stall(ppu_stall)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle frame_end pulse; afterwards the registered swap is visible.
  task automatic fe_pulse();
    frame_end = 1'b1;
    step(1);
    frame_end = 1'b0;
  endtask

  task automatic toggle();
    done_tgl = ~done_tgl;
  endtask

  initial begin
    rstn      = 1'b0;
    sync_en   = 1'b1;
    frame_end = 1'b0;
    done_tgl  = 1'b0;
    cnt_clr   = 1'b0;
    #12;
    chk("rst_rd", 32'(rd_page), 32'd1);
    chk("rst_wr", 32'(wr_page), 32'd0);
    chk("rst_swap", 32'(swap), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_repeat", 32'(repeat_cnt), 32'd0);
    chk("rst_stall", 32'(ppu_stall), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(2);

    // Three frames with no PPU done: repeats only, no swap.
    for (int k = 0; k < 3; k++) begin
      fe_pulse();
      chk("norm_swap", 32'(swap), 32'd0);
      step(3);
    end
    chk("rep3_cnt", 32'(repeat_cnt), 32'd3);
    chk("rep3_rd", 32'(rd_page), 32'd1);
    chk("rep3_wr", 32'(wr_page), 32'd0);

    // Mid-frame done: pending after SYNC_STAGES+1 cycles, swap at frame end.
    toggle();
    step(2);
    chk("pend_early", 32'(pending), 32'd0);
    step(1);
    chk("pend_set", 32'(pending), 32'd1);
    step(3);
    fe_pulse();
    chk("swap1_rd", 32'(rd_page), 32'd0);
    chk("swap1_wr", 32'(wr_page), 32'd1);
    chk("swap1_pulse", 32'(swap), 32'd1);
    chk("swap1_pend", 32'(pending), 32'd0);
    step(1);
    chk("swap1_single", 32'(swap), 32'd0);
    chk("swap1_rep", 32'(repeat_cnt), 32'd3);

    // Two dones within one frame: one drop, one swap.
    toggle();
    step(5);
    toggle();
    step(2);
    chk("drop_early", 32'(drop_cnt), 32'd0);
    step(1);
    chk("drop1_cnt", 32'(drop_cnt), 32'd1);
    chk("drop1_pend", 32'(pending), 32'd1);
    step(2);
    fe_pulse();
    chk("drop1_rd", 32'(rd_page), 32'd1);
    chk("drop1_wr", 32'(wr_page), 32'd0);
    chk("drop1_swap", 32'(swap), 32'd1);
    step(1);
    chk("drop1_single", 32'(swap), 32'd0);

    // Done coincident with frame_end in IDLE: immediate swap, never pending.
    toggle();
    step(2);
    chk("coin_idle_pre", 32'(pending), 32'd0);
    fe_pulse();
    chk("coin_idle_pend", 32'(pending), 32'd0);
    chk("coin_idle_swap", 32'(swap), 32'd1);
    chk("coin_idle_rd", 32'(rd_page), 32'd0);
    chk("coin_idle_wr", 32'(wr_page), 32'd1);
    chk("coin_idle_rep", 32'(repeat_cnt), 32'd3);
    step(2);

    // Done coincident with frame_end in PENDING: drop and swap.
    toggle();
    step(3);
    chk("coin_pend_set", 32'(pending), 32'd1);
    toggle();
    step(2);
    fe_pulse();
    chk("coin_pend_drop", 32'(drop_cnt), 32'd2);
    chk("coin_pend_rd", 32'(rd_page), 32'd1);
    chk("coin_pend_wr", 32'(wr_page), 32'd0);
    chk("coin_pend_swap", 32'(swap), 32'd1);
    chk("coin_pend_pend", 32'(pending), 32'd0);
    step(2);

    // Stall after 8 frames without done.
    for (int k = 1; k <= 8; k++) begin
      fe_pulse();
      if (k == 7) chk("stall_7", 32'(ppu_stall), 32'd0);
      step(2);
    end
    chk("stall_8", 32'(ppu_stall), 32'd1);
    chk("stall_rep", 32'(repeat_cnt), 32'd11);
    toggle();
    step(2);
    chk("stall_hold", 32'(ppu_stall), 32'd1);
    step(1);
    chk("stall_clr", 32'(ppu_stall), 32'd0);
    chk("stall_pend", 32'(pending), 32'd1);
    step(1);
    fe_pulse();
    chk("stall_swap_rd", 32'(rd_page), 32'd0);
    chk("stall_swap_wr", 32'(wr_page), 32'd1);
    step(2);

    // Clear coincident with a repeat increment: clear wins.
    cnt_clr = 1'b1;
    fe_pulse();
    cnt_clr = 1'b0;
    chk("clr_rep", 32'(repeat_cnt), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_stall", 32'(ppu_stall), 32'd0);
    step(2);

    // Free-run: toggle every frame, done ignored, counters frozen.
    sync_en = 1'b0;
    step(1);
    fe_pulse();
    chk("free1_rd", 32'(rd_page), 32'd1);
    chk("free1_wr", 32'(wr_page), 32'd0);
    chk("free1_swap", 32'(swap), 32'd1);
    toggle();
    step(4);
    chk("free_pend", 32'(pending), 32'd0);
    fe_pulse();
    chk("free2_rd", 32'(rd_page), 32'd0);
    chk("free2_wr", 32'(wr_page), 32'd1);
    step(2);
    fe_pulse();
    chk("free3_rd", 32'(rd_page), 32'd1);
    chk("free3_wr", 32'(wr_page), 32'd0);
    chk("free_rep", 32'(repeat_cnt), 32'd0);
    chk("free_drop", 32'(drop_cnt), 32'd0);
    step(2);

    // Drop sync_en while pending: discarded, no swap at next frame end.
    sync_en = 1'b1;
    toggle();
    step(3);
    chk("dis_pend_set", 32'(pending), 32'd1);
    sync_en = 1'b0;
    step(1);
    chk("dis_pend_clr", 32'(pending), 32'd0);
    sync_en = 1'b1;
    step(2);
    fe_pulse();
    chk("dis_swap", 32'(swap), 32'd0);
    chk("dis_rd", 32'(rd_page), 32'd1);
    chk("dis_wr", 32'(wr_page), 32'd0);
    chk("dis_rep", 32'(repeat_cnt), 32'd1);
    chk("dis_drop", 32'(drop_cnt), 32'd0);
    step(2);

    // Reset mid-frame: outputs return to reset values immediately.
    toggle();
    step(3);
    fe_pulse();
    chk("pre_rst_rd", 32'(rd_page), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_rd", 32'(rd_page), 32'd1);
    chk("midrst_wr", 32'(wr_page), 32'd0);
    chk("midrst_swap", 32'(swap), 32'd0);
    chk("midrst_rep", 32'(repeat_cnt), 32'd0);
    step(2);
    rstn = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_vbuf_page_sched.md
Name: ppu_vbuf_page_sched

Overview:
- Double-buffer page scheduler for the 2-page video buffer (address bit 16 selects the page).
- Decides which page the LCD scanout reads (o_rd_page) and which page the PPU renders into (o_wr_page). Pages swap only at the LCD frame boundary, so a half-rendered frame is never displayed.
- Lives in the LCD clock domain. Receives the PPU frame-done event as a toggle and reports dropped frames, repeated frames and PPU stall.

Parameters:
- SYNC_STAGES, 2, flop count of the synchronizer on i_ppu_done_tgl (min 2).
- TIMEOUT_FRAMES, 8, LCD frames without a PPU done before o_ppu_stall asserts (1..255).
- CNT_W, 16, width of drop/repeat statistics counters.

Ports:
- i_lcd_clk  in  1  LCD pixel clock.
- i_lcd_rstn  in  1  reset.
- i_sync_en  in  1  1 = synchronized swap; 0 = free-run toggle every LCD frame.
- i_frame_end  in  1  one-cycle pulse on the last cycle of an LCD frame (xcnt 1055, line 524).
- i_ppu_done_tgl  in  1  PPU-domain level; toggles once per completed PPU frame; asynchronous.
- i_cnt_clr  in  1  synchronous clear of statistics counters and stall flag.
- o_rd_page  out  1  page bit used by LCD scanout.
- o_wr_page  out  1  page bit used by PPU writes; quasi-static; PPU samples it at its frame start.
- o_swap  out  1  one-cycle pulse, cycle after a swap is applied.
- o_pending  out  1  a completed frame is waiting for display.
- o_drop_cnt  out  CNT_W  PPU frames overwritten before display (saturating).
- o_repeat_cnt  out  CNT_W  LCD frames that re-displayed the previous page (saturating).
- o_ppu_stall  out  1  no PPU frame done for TIMEOUT_FRAMES LCD frames.

Behaviour:
- Reset (i_lcd_rstn asynchronous, active-low; clock i_lcd_clk):
  - o_rd_page=1, o_wr_page=0.
  - o_swap=0, o_pending=0, counters=0, o_ppu_stall=0.
  - Synchronizer flops, and the edge-detect flop that follows them, reset to 0.
  - State IDLE.
- CDC and done event:
  - i_ppu_done_tgl passes through SYNC_STAGES flops, then edge detect (XOR with previous value).
  - done = any edge. Latency: the edge appears 1 cycle after the last sync stage.
- State machine (evaluated only while i_sync_en=1):
  - IDLE:
    - done and not frame_end: go to PENDING, o_pending=1.
    - done and frame_end in the same cycle: swap now, stay IDLE.
    - frame_end alone: o_repeat_cnt+1.
  - PENDING:
    - frame_end: swap, go to IDLE, o_pending=0.
    - done without frame_end: o_drop_cnt+1, stay PENDING. The same write page was fully overwritten, so the newer frame is the one displayed.
    - done and frame_end in the same cycle: o_drop_cnt+1, then swap.
- Swap:
  - o_rd_page <= o_wr_page and o_wr_page <= ~o_wr_page, registered on the frame_end cycle, so both are visible on the first cycle of the next frame.
  - o_swap=1 on that next cycle.
  - Invariant: o_rd_page != o_wr_page at all times in sync mode.
- Free-run (i_sync_en=0):
  - Every frame_end toggles both o_rd_page and o_wr_page; o_swap pulses.
  - State forced to IDLE, o_pending=0.
  - Counters and stall timer frozen. Done edges are still tracked by the edge detector but otherwise ignored.
- i_sync_en falling while PENDING: pending frame discarded, IDLE next cycle, no counter change.
- i_sync_en rising: continue from the current page values.
- Stall timer (8-bit):
  - Cleared on done.
  - +1 on each frame_end without done; saturates at TIMEOUT_FRAMES.
  - o_ppu_stall = (timer == TIMEOUT_FRAMES), registered.
  - A done edge clears o_ppu_stall the next cycle.
- Counters:
  - Saturate at all-ones; never wrap.
  - i_cnt_clr has priority over increments in the same cycle, and also clears the stall timer.
- Reset mid-frame: all outputs return to reset values immediately. A toggle already in flight in the synchronizer is lost, which is acceptable.

Test Plan:
- Reset, then 3 frame_ends with no done -> o_rd_page=1 and o_wr_page=0 unchanged, o_repeat_cnt=3, o_swap never pulses.
- Toggle done at mid-frame -> o_pending=1 SYNC_STAGES+1 cycles later. At next frame_end -> o_rd_page=0, o_wr_page=1 the following cycle, o_swap single pulse, o_pending=0.
- Two done toggles within one LCD frame -> o_drop_cnt=1, exactly one swap at frame_end.
- Done edge coincident with frame_end in IDLE -> immediate swap, o_pending never asserts. Coincident in PENDING -> o_drop_cnt+1 and swap.
- TIMEOUT_FRAMES=8, no done for 8 frame_ends -> o_ppu_stall=1 after 8th. One done toggle -> stall=0. i_cnt_clr together with a frame_end repeat increment -> o_repeat_cnt=0.
- i_sync_en=0 -> pages toggle every frame_end regardless of done, counters frozen. Drop i_sync_en while PENDING -> o_pending=0 next cycle, no swap at the following frame_end unless a new done arrives.
